// File: rtl/i2s_transmitter.sv
// I2S transmitter: derives bclk/lrclk from clk, serialises one stereo pair per frame
// from a single-entry holding register, and flags frames that start without data.
module i2s_transmitter #(
  parameter int WIDTH     = 24,
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] WIDTH_B  = BIT_W'(WIDTH);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_next;
  logic [BIT_W-1:0] slot_k;
  logic             right_slot;
  logic             fall;
  logic             xfer;
  logic             hold_full;
  logic [WIDTH-1:0] hold_l;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] shift_l;
  logic [WIDTH-1:0] shift_r;

  always_comb begin
    fall       = (div_cnt == DIV_LAST) && bclk;
    xfer       = sample_valid && sample_ready;
    bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    right_slot = (bit_next >= SLOT_B);
    slot_k     = right_slot ? (bit_next - SLOT_B) : bit_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt      <= '0;
      bit_cnt      <= BIT_LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
    end else if (!enable) begin
      div_cnt      <= '0;
      bit_cnt      <= BIT_LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b1;
      sdata        <= 1'b0;
      sample_ready <= 1'b0;
      underrun     <= 1'b0;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
    end else begin
      underrun <= 1'b0;
      // ready reflects the holding register as of this edge, so it rises one clk after a drain
      sample_ready <= !hold_full && !xfer;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (xfer) begin
        hold_l    <= sample_l;
        hold_r    <= sample_r;
        hold_full <= 1'b1;
      end

      if (fall) begin
        bit_cnt <= bit_next;
        lrclk   <= right_slot;
        sdata   <= 1'b0;
        if (bit_next == '0) begin
          if (hold_full) begin
            shift_l   <= hold_l;
            shift_r   <= hold_r;
            hold_full <= 1'b0;
          end else begin
            shift_l  <= '0;
            shift_r  <= '0;
            underrun <= 1'b1;
          end
        end else if ((slot_k != '0) && (slot_k <= WIDTH_B)) begin
          if (right_slot) begin
            sdata   <= shift_r[WIDTH-1];
            shift_r <= shift_r << 1;
          end else begin
            sdata   <= shift_l[WIDTH-1];
            shift_l <= shift_l << 1;
          end
        end
      end
    end
  end

endmodule
